// File: rtl/window_streamer_if.sv
// Bundles the start/origin request, the image SRAM read port and the tap stream
// that feeds the gradient stage; master is the streamer, slave is its environment.
interface window_streamer_if #(
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int PIX_W  = 8,
  parameter int DATA_W = 14,
  parameter int ADDR_W = 6,
  parameter int X_W    = $clog2(IMG_W),
  parameter int Y_W    = $clog2(IMG_H)
);
  logic              i_start;
  logic [X_W-1:0]    i_ox;
  logic [Y_W-1:0]    i_oy;
  logic              o_busy;
  logic              o_done;
  logic              o_sram_ren;
  logic [ADDR_W-1:0] o_sram_addr;
  logic [PIX_W-1:0]  i_sram_rdata;
  logic              o_filter_valid;
  logic [3:0]        o_count;
  logic [DATA_W-1:0] o_data;

  modport master (
    input  i_start, i_ox, i_oy, i_sram_rdata,
    output o_busy, o_done, o_sram_ren, o_sram_addr, o_filter_valid, o_count, o_data
  );

  modport slave (
    output i_start, i_ox, i_oy, i_sram_rdata,
    input  o_busy, o_done, o_sram_ren, o_sram_addr, o_filter_valid, o_count, o_data
  );
endinterface

// File: rtl/window_streamer.sv
// Streams the four 3x3 neighbourhoods of a 2x2 output block from the image SRAM,
// zero-padding out-of-image taps and marking window boundaries for the gradient stage.
module window_streamer #(
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int PIX_W  = 8,
  parameter int DATA_W = 14,
  parameter int ADDR_W = 6
) (
  input logic               clk,
  input logic               rst_n,
  window_streamer_if.master ws
);
  localparam int X_W = $clog2(IMG_W);
  localparam int Y_W = $clog2(IMG_H);
  // Two spare bits: one for the sign, one for centres one past the last pixel.
  localparam int CW  = ((X_W > Y_W) ? X_W : Y_W) + 2;

  localparam logic signed [CW-1:0] ZERO_S  = '0;
  localparam logic signed [CW-1:0] ONE_S   = CW'(1);
  localparam logic signed [CW-1:0] IMG_W_S = CW'(IMG_W);
  localparam logic signed [CW-1:0] IMG_H_S = CW'(IMG_H);

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DONE} state_t;

  state_t            state, state_n;
  logic [1:0]        win, win_n;
  logic [3:0]        tap, tap_n;
  logic [X_W-1:0]    ox_q, ox_n;
  logic [Y_W-1:0]    oy_q, oy_n;
  logic              load_tap;
  logic              fv_n;

  logic signed [CW-1:0] tap_px, tap_py;
  logic                 pad;
  logic [ADDR_W-1:0]    tap_addr;

  logic [3:0]        count_q, count_n;
  logic              ren_q, ren_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic              fv_q;
  logic              rd_flag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Decide which tap (if any) is presented next cycle; outputs are registered from it.
  always_comb begin
    state_n  = state;
    win_n    = win;
    tap_n    = tap;
    ox_n     = ox_q;
    oy_n     = oy_q;
    load_tap = 1'b0;
    fv_n     = 1'b0;
    case (state)
      IDLE: begin
        if (ws.i_start) begin
          state_n  = STREAM;
          win_n    = 2'd0;
          tap_n    = 4'd0;
          ox_n     = ws.i_ox;
          oy_n     = ws.i_oy;
          load_tap = 1'b1;
        end
      end
      STREAM: begin
        if (tap == 4'd8) begin
          fv_n = 1'b1;
          if (win == 2'd3) begin
            state_n = FLUSH;
          end else begin
            win_n    = win + 2'd1;
            tap_n    = 4'd0;
            load_tap = 1'b1;
          end
        end else begin
          tap_n    = tap + 4'd1;
          load_tap = 1'b1;
        end
      end
      FLUSH:   state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    tap_px   = $signed(CW'(ox_n)) + $signed(CW'(win_n[0])) + $signed(CW'(tap_n % 4'd3)) - ONE_S;
    tap_py   = $signed(CW'(oy_n)) + $signed(CW'(win_n[1])) + $signed(CW'(tap_n / 4'd3)) - ONE_S;
    pad      = (tap_px < ZERO_S) || (tap_px >= IMG_W_S) || (tap_py < ZERO_S) || (tap_py >= IMG_H_S);
    tap_addr = ADDR_W'($unsigned(tap_py)) * ADDR_W'(IMG_W) + ADDR_W'($unsigned(tap_px));
    count_n  = load_tap ? tap_n : 4'hF;
    ren_n    = load_tap && !pad;
    addr_n   = ren_n ? tap_addr : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win     <= '0;
      tap     <= '0;
      ox_q    <= '0;
      oy_q    <= '0;
      count_q <= 4'hF;
      ren_q   <= 1'b0;
      addr_q  <= '0;
      fv_q    <= 1'b0;
      rd_flag <= 1'b0;
    end else begin
      win     <= win_n;
      tap     <= tap_n;
      ox_q    <= ox_n;
      oy_q    <= oy_n;
      count_q <= count_n;
      ren_q   <= ren_n;
      addr_q  <= addr_n;
      fv_q    <= fv_n;
      rd_flag <= ren_q;
    end
  end

  // The SRAM answers one cycle after the read, so padded taps are forced to zero here.
  assign ws.o_data         = rd_flag ? DATA_W'(ws.i_sram_rdata) : '0;
  assign ws.o_busy         = (state != IDLE);
  assign ws.o_done         = (state == DONE);
  assign ws.o_sram_ren     = ren_q;
  assign ws.o_sram_addr    = addr_q;
  assign ws.o_filter_valid = fv_q;
  assign ws.o_count        = count_q;
endmodule

// File: tb/tb_window_streamer.sv
// Scoreboard bench for window_streamer: a per-cycle expected record queue built from the
// geometry, an SRAM model, and a small Sobel accumulator standing in for the gradient stage.
module tb_window_streamer;
  localparam int PERIOD = 10;

  typedef struct {
    int cyc;
    int count;
    int ren;
    int addr;
    int fv;
    int data;
    int busy;
    int done;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;

  window_streamer_if ws_if ();

  window_streamer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ws    (ws_if)
  );

  always #(PERIOD / 2) clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] mem [64];
  always @(posedge clk) if (ws_if.o_sram_ren) ws_if.i_sram_rdata <= mem[ws_if.o_sram_addr];

  exp_t sb[$];
  exp_t mon_rec;
  int   checks = 0;
  int   errors = 0;

  bit   grad_en    = 1'b0;
  int   prev_count = 15;
  int   acc_x      = 0;
  int   acc_y      = 0;
  int   contrib_x, contrib_y;
  int   grad_x[$];
  int   grad_y[$];
  int   kx [9] = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
  int   ky [9] = '{-1, -2, -1, 0, 0, 0, 1, 2, 1};

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, observed, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pushIdle(input int from, input int n);
    exp_t r;
    for (int i = 0; i < n; i++) begin
      r = '{cyc: from + i, count: 15, ren: 0, addr: 0, fv: 0, data: 0, busy: 0, done: 0};
      sb.push_back(r);
    end
  endtask

  // Expected outputs for cycles base+1 .. base+39 of a block started at cycle base.
  task automatic pushBlock(input int base, input int ox, input int oy);
    exp_t r [40];
    int t, cx, cy, px, py, a;
    bit pad;
    for (int i = 1; i <= 39; i++)
      r[i] = '{cyc: base + i, count: 15, ren: 0, addr: 0, fv: 0, data: 0,
               busy: (i < 39) ? 1 : 0, done: 0};
    for (int w = 0; w < 4; w++) begin
      for (int k = 0; k < 9; k++) begin
        t   = 1 + 9 * w + k;
        cx  = ox + (w % 2);
        cy  = oy + (w / 2);
        px  = cx + (k % 3) - 1;
        py  = cy + (k / 3) - 1;
        pad = (px < 0) || (px >= 8) || (py < 0) || (py >= 8);
        a   = pad ? 0 : py * 8 + px;
        r[t].count = k;
        r[t].ren   = pad ? 0 : 1;
        r[t].addr  = a;
        r[t].fv    = (k == 0 && w > 0) ? 1 : 0;
        if (!pad) r[t + 1].data = int'(mem[a]);
      end
    end
    r[37].fv   = 1;
    r[38].done = 1;
    for (int i = 1; i <= 39; i++) sb.push_back(r[i]);
  endtask

  task automatic applyStimulus(input int ox, input int oy);
    ws_if.i_ox    = 3'(ox);
    ws_if.i_oy    = 3'(oy);
    ws_if.i_start = 1'b1;
    pushBlock(cyc, ox, oy);
    nextCycle();
    ws_if.i_start = 1'b0;
    repeat (38) nextCycle();
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon_rec = sb.pop_front();
      if (mon_rec.cyc != cyc) begin
        checkOutput("sb_order", 32'(mon_rec.cyc), 32'(cyc));
      end else begin
        checkOutput("count", 32'(ws_if.o_count),        32'(mon_rec.count));
        checkOutput("ren",   32'(ws_if.o_sram_ren),     32'(mon_rec.ren));
        checkOutput("addr",  32'(ws_if.o_sram_addr),    32'(mon_rec.addr));
        checkOutput("fv",    32'(ws_if.o_filter_valid), 32'(mon_rec.fv));
        checkOutput("data",  32'(ws_if.o_data),         32'(mon_rec.data));
        checkOutput("busy",  32'(ws_if.o_busy),         32'(mon_rec.busy));
        checkOutput("done",  32'(ws_if.o_done),         32'(mon_rec.done));
      end
    end
    if (grad_en) begin
      contrib_x = (prev_count < 9) ? kx[prev_count] * int'(ws_if.o_data) : 0;
      contrib_y = (prev_count < 9) ? ky[prev_count] * int'(ws_if.o_data) : 0;
      if (ws_if.o_filter_valid) begin
        grad_x.push_back(acc_x + contrib_x);
        grad_y.push_back(acc_y + contrib_y);
        acc_x = 0;
        acc_y = 0;
      end else begin
        acc_x += contrib_x;
        acc_y += contrib_y;
      end
      prev_count = int'(ws_if.o_count);
    end
  end

  initial begin
    #(PERIOD * 5000);
    $display("[TB] FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base, next_free;
    ws_if.i_start = 1'b0;
    ws_if.i_ox    = '0;
    ws_if.i_oy    = '0;
    for (int i = 0; i < 64; i++) mem[i] = 8'(i);

    nextCycle();
    pushIdle(cyc, 4);
    repeat (2) nextCycle();
    rst_n = 1'b1;
    repeat (2) nextCycle();

    $display("[TB] address image, origins (2,3), (0,0), (7,7)");
    applyStimulus(2, 3);
    applyStimulus(0, 0);
    applyStimulus(7, 7);

    $display("[TB] start held high for 50 cycles");
    base          = cyc;
    next_free     = base;
    ws_if.i_ox    = 3'd1;
    ws_if.i_oy    = 3'd4;
    ws_if.i_start = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (cyc >= next_free) begin
        pushBlock(cyc, 1, 4);
        next_free = cyc + 39;
      end
      nextCycle();
    end
    ws_if.i_start = 1'b0;
    while (cyc < next_free) nextCycle();

    $display("[TB] reset asserted mid-block");
    base          = cyc;
    ws_if.i_ox    = 3'd2;
    ws_if.i_oy    = 3'd3;
    ws_if.i_start = 1'b1;
    pushBlock(base, 2, 3);
    nextCycle();
    ws_if.i_start = 1'b0;
    repeat (14) nextCycle();
    rst_n = 1'b0;
    while (sb.size() > 0 && sb[$].cyc >= cyc) void'(sb.pop_back());
    pushIdle(cyc, 30);
    repeat (3) nextCycle();
    rst_n = 1'b1;
    repeat (27) nextCycle();
    applyStimulus(3, 5);

    $display("[TB] uniform image through gradient model");
    for (int i = 0; i < 64; i++) mem[i] = 8'd100;
    acc_x      = 0;
    acc_y      = 0;
    prev_count = 15;
    grad_x.delete();
    grad_y.delete();
    grad_en    = 1'b1;
    applyStimulus(2, 2);
    grad_en    = 1'b0;
    checkOutput("grad_outputs", 32'(grad_x.size()), 32'd4);
    for (int i = 0; i < grad_x.size(); i++) begin
      checkOutput("grad_x", 32'(grad_x[i]), 32'd0);
      checkOutput("grad_y", 32'(grad_y[i]), 32'd0);
    end
    checkOutput("acc_x_after_flush", 32'(acc_x), 32'd0);
    checkOutput("acc_y_after_flush", 32'(acc_y), 32'd0);

    $display("[TB] random images and origins");
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 64; i++) mem[i] = 8'($urandom_range(0, 255));
      applyStimulus(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
    end

    repeat (3) nextCycle();
    checkOutput("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/window_streamer.md
# window_streamer

Upstream feeder for the gradient/NMS stage. On a start pulse it reads the 3x3 neighbourhoods of a 2x2 block of output pixels from the single-port image SRAM. It streams the taps in raster order with a tap index, zero-pads out-of-image taps, and emits the window-boundary `filter_valid` pulses the gradient stage needs. It produces exactly four boundary pulses per block, the last one being a flush, so the downstream stage stores four gradient/angle pairs and its accumulators end at zero.

## Interface
- `IMG_W`, 8, image width in pixels
- `IMG_H`, 8, image height in pixels
- `PIX_W`, 8, SRAM pixel width
- `DATA_W`, 14, streamed data width (pixel zero-extended)
- `ADDR_W`, 6, SRAM address width (log2(IMG_W*IMG_H))
- `clk`  in  1  single clock, all state on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `i_start`  in  1  one-cycle start request; sampled only in IDLE
- `i_ox`  in  3  block origin column (0..IMG_W-1)
- `i_oy`  in  3  block origin row (0..IMG_H-1)
- `o_busy`  out  1  high from the cycle after start acceptance through DONE
- `o_done`  out  1  one-cycle pulse, block finished
- `o_sram_ren`  out  1  SRAM read enable
- `o_sram_addr`  out  ADDR_W  read address = py*IMG_W + px
- `i_sram_rdata`  in  PIX_W  read data, valid the cycle after `o_sram_ren`
- `o_filter_valid`  out  1  window-boundary pulse to gradient stage
- `o_count`  out  4  tap index 0..8; 15 when no tap is presented
- `o_data`  out  DATA_W  tap value, one cycle after its `o_count`

## Operation
- States: IDLE, STREAM, FLUSH, DONE.
  - IDLE→STREAM on `i_start`. `i_ox`/`i_oy` are latched on that cycle.
  - STREAM runs 36 cycles: 4 windows × 9 taps.
  - STREAM→FLUSH after window 3 tap 8.
  - FLUSH→DONE after 1 cycle.
  - DONE→IDLE after 1 cycle.
- Window w (0..3) has centre cx = ox + w[0], cy = oy + w[1]. This order is fixed: G0 = origin, G1 = right, G2 = below, G3 = diagonal.
- Tap k (0..8) reads px = cx + (k mod 3) − 1, py = cy + (k div 3) − 1.
  - Use signed compare with at least 5-bit coordinates.
  - A tap is padded when px<0, px≥IMG_W, py<0 or py≥IMG_H.
- Per STREAM cycle, all registered:
  - `o_count` = k.
  - `o_sram_ren` = !padded.
  - `o_sram_addr` = address when not padded, else 0.
- `o_data` = {zeros, `i_sram_rdata`} when the previous cycle issued a read; otherwise 0. It is gated by a registered read flag.
- `o_filter_valid`:
  - High on the tap-0 cycle of windows 1, 2 and 3.
  - High in FLUSH, with `o_count`=15 and `o_sram_ren`=0.
  - Never high for window 0.
- Outside STREAM, `o_count`=15, `o_sram_ren`=0 and `o_sram_addr`=0. The downstream kernel then contributes 0.
- `i_start` outside IDLE is ignored and not queued.
- Origin 7 is legal; out-of-image centres simply pad.

## Timing
- Reset values:
  - state IDLE
  - `o_busy`=0, `o_done`=0, `o_sram_ren`=0, `o_sram_addr`=0
  - `o_filter_valid`=0, `o_count`=15, `o_data`=0, read flag 0
- Start sampled at edge of cycle 0:
  - Tap k of window w is presented at cycle 1+9w+k.
  - Its data appears at cycle 2+9w+k.
- `o_filter_valid` is high at cycles 10, 19, 28 and 37 (FLUSH).
- DONE is cycle 38: `o_done`=1, `o_busy`=1.
- Cycle 39: IDLE, `o_busy`=0. The earliest next accepted start is sampled at cycle 39.
- Block period is 39 cycles. Windows are back-to-back with no bubbles.
- Reset mid-operation: everything returns to reset values immediately, with no `o_done` and no further `o_filter_valid`.

## Test plan
- Image pix(x,y)=8y+x, start ox=2, oy=3:
  - Window 0 addresses 17,18,19,25,26,27,33,34,35 at cycles 1..9.
  - `o_data` equals the address value one cycle later.
  - Window 1 starts at address 18, cycle 10.
  - `o_filter_valid` at exactly cycles 10, 19, 28, 37.
- ox=0, oy=0:
  - Window 0 taps 0,1,2,3,6 are padded: `o_sram_ren`=0, `o_data`=0.
  - Tap 4 reads address 0; tap 8 reads address 9.
- ox=7, oy=7:
  - Window 3 (centre 8,8) reads only tap 0, address 63.
  - Every other window-3 tap has `o_sram_ren`=0 and `o_data`=0.
- Start held high for 50 cycles:
  - Exactly one block per 39 cycles; second block's tap 0 at cycle 40.
  - Starts during busy cycles 1..38 are ignored.
- Assert `rst_n`=0 at cycle 15:
  - Outputs go to reset values at once; no `o_done`.
  - A start after release runs a complete, correct block.
- Integration with the gradient stage, uniform image value 100:
  - The gradient stage produces four outputs, all 0, and its finish flag is set.
  - Accumulators are 0 after FLUSH.
